// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Slave end of the 6502 CPU memory bus. Decodes every CPU access in the NES
//   CPU address map: serves the mirrored work RAM, forwards PPU-register and
//   PRG-ROM accesses to their owners, and runs the OAM DMA engine that a write
//   to $4014 starts (256 bytes from page {data,00..FF} into PPU register 4).
//
// Ports
//   clk, rst           system clock, asynchronous active-low reset
//   cpu_addr           CPU bus address
//   cpu_wr_data        CPU write data
//   cpu_write_en       write request this cycle (wins over a read)
//   cpu_read_en        read request this cycle
//   cpu_rd_data        read response, valid the cycle after the read, then held
//   dma_busy           OAM DMA in progress; CPU requests are ignored
//   ppu_reg_addr       PPU register index for ppu_wr / ppu_rd
//   ppu_wr_data        PPU write data
//   ppu_wr, ppu_rd     one-cycle PPU register strobes
//   ppu_rd_data        PPU read data, valid the cycle after ppu_rd
//   prg_addr           PRG-ROM byte address for prg_rd
//   prg_rd             one-cycle PRG read strobe
//   prg_data           PRG data, valid the cycle after prg_rd
module cpu_mem_responder #(
    parameter int RAM_AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [7:0]  cpu_rd_data,
    output logic        dma_busy,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_wr_data,
    output logic        ppu_wr,
    output logic        ppu_rd,
    input  logic [7:0]  ppu_rd_data,
    output logic [14:0] prg_addr,
    output logic        prg_rd,
    input  logic [7:0]  prg_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ALIGN2, S_READ, S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        R_RAM, R_PPU, R_PRG, R_ZERO
    } region_t;

    function automatic region_t decode(input logic [15:0] a);
        if (a[15:13] == 3'b000)      return R_RAM;
        else if (a[15:13] == 3'b001) return R_PPU;
        else if (a[15])              return R_PRG;
        else                         return R_ZERO;  // APU/IO, $4014 reads, expansion, SRAM
    endfunction

    state_t        state, state_nxt;
    logic          parity;
    logic          odd_q;        // parity sampled in the trigger cycle
    logic [7:0]    page_q;
    logic [7:0]    idx_q;
    logic          wr_acc, rd_acc, dma_rd, any_rd, trigger;
    logic [15:0]   bus_addr;
    region_t       region, sel_q;
    logic          rd_pend_q;
    logic [7:0]    ram [0:(1<<RAM_AW)-1];
    logic [7:0]    ram_q;
    logic [7:0]    rd_mux;
    logic [7:0]    rd_hold_q;

    assign dma_busy = (state != S_IDLE);
    assign wr_acc   = cpu_write_en & ~dma_busy;
    assign rd_acc   = cpu_read_en & ~cpu_write_en & ~dma_busy;
    assign dma_rd   = (state == S_READ);
    assign any_rd   = rd_acc | dma_rd;
    assign trigger  = wr_acc && (cpu_addr == 16'h4014);

    // The DMA engine borrows the bus in READ; the CPU is stalled then anyway.
    assign bus_addr = dma_rd ? {page_q, idx_q} : cpu_addr;
    assign region   = decode(bus_addr);

    // Strobes and their side-band signals, zero whenever nothing is issued.
    always_comb begin
        ppu_wr       = 1'b0;
        ppu_rd       = 1'b0;
        prg_rd       = 1'b0;
        ppu_reg_addr = 3'd0;
        ppu_wr_data  = 8'h00;
        prg_addr     = 15'd0;
        if (state == S_WRITE) begin
            ppu_wr       = 1'b1;
            ppu_reg_addr = 3'd4;      // OAMDATA
            ppu_wr_data  = rd_mux;    // byte fetched in the preceding READ
        end else if (wr_acc && region == R_PPU) begin
            ppu_wr       = 1'b1;
            ppu_reg_addr = bus_addr[2:0];
            ppu_wr_data  = cpu_wr_data;
        end else if (any_rd && region == R_PPU) begin
            ppu_rd       = 1'b1;
            ppu_reg_addr = bus_addr[2:0];
        end else if (any_rd && region == R_PRG) begin
            prg_rd       = 1'b1;
            prg_addr     = bus_addr[14:0];
        end
    end

    // Work RAM: synchronous single port, read port registered every cycle.
    always_ff @(posedge clk) begin
        if (wr_acc && region == R_RAM)
            ram[bus_addr[RAM_AW-1:0]] <= cpu_wr_data;
        ram_q <= ram[bus_addr[RAM_AW-1:0]];
    end

    // Return path: the region registered with the request picks the source.
    always_comb begin
        case (sel_q)
            R_RAM:   rd_mux = ram_q;
            R_PPU:   rd_mux = ppu_rd_data;
            R_PRG:   rd_mux = prg_data;
            default: rd_mux = 8'h00;
        endcase
    end

    // Only CPU reads update the visible response; DMA reads never set rd_pend_q.
    assign cpu_rd_data = rd_pend_q ? rd_mux : rd_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            parity    <= 1'b0;
            odd_q     <= 1'b0;
            idx_q     <= 8'd0;
            sel_q     <= R_ZERO;
            rd_pend_q <= 1'b0;
            rd_hold_q <= 8'h00;
        end else begin
            state     <= state_nxt;
            parity    <= ~parity;
            sel_q     <= region;
            rd_pend_q <= rd_acc;
            rd_hold_q <= cpu_rd_data;
            if (trigger) begin
                odd_q <= parity;
                idx_q <= 8'd0;
            end else if (state == S_WRITE) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (trigger)
            page_q <= cpu_wr_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (trigger) state_nxt = S_ALIGN;
            S_ALIGN:  state_nxt = odd_q ? S_ALIGN2 : S_READ;
            S_ALIGN2: state_nxt = S_READ;
            S_READ:   state_nxt = S_WRITE;
            S_WRITE:  state_nxt = (idx_q == 8'hFF) ? S_IDLE : S_READ;
            default:  state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [7:0]  cpu_rd_data;
    logic        dma_busy;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_wr_data;
    logic        ppu_wr;
    logic        ppu_rd;
    logic [7:0]  ppu_rd_data;
    logic [14:0] prg_addr;
    logic        prg_rd;
    logic [7:0]  prg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram_m [0:2047];   // reference work RAM
    logic       tb_par;           // cycle parity since reset release

    always #5 clk = ~clk;

    cpu_mem_responder #(.RAM_AW(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_write_en (cpu_write_en),
        .cpu_read_en  (cpu_read_en),
        .cpu_rd_data  (cpu_rd_data),
        .dma_busy     (dma_busy),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_wr_data  (ppu_wr_data),
        .ppu_wr       (ppu_wr),
        .ppu_rd       (ppu_rd),
        .ppu_rd_data  (ppu_rd_data),
        .prg_addr     (prg_addr),
        .prg_rd       (prg_rd),
        .prg_data     (prg_data)
    );

    always @(posedge clk or negedge rst)
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;

    // Cartridge ROM stand-in: content is a fixed function of the address.
    function automatic logic [7:0] rom_byte(input logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    always @(posedge clk)
        if (prg_rd) prg_data <= rom_byte(prg_addr);

    // What a read of address a must return under the CPU memory map.
    function automatic logic [7:0] exp_read(input logic [15:0] a);
        if (a < 16'h2000)      return ram_m[a[10:0]];
        else if (a < 16'h4000) return ppu_rd_data;
        else if (a >= 16'h8000) return rom_byte(a[14:0]);
        else                   return 8'h00;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wr_data = d; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
        tick;
        cpu_write_en = 1'b0;
        if (a < 16'h2000) ram_m[a[10:0]] = d;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpu_addr = a; cpu_read_en = 1'b1; cpu_write_en = 1'b0;
        tick;
        cpu_read_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cpu_addr = 16'h0; cpu_wr_data = 8'h0; cpu_write_en = 1'b0; cpu_read_en = 1'b0;
        ppu_rd_data = 8'h00;
        repeat (3) tick;
        n_checks++;
        if ({cpu_rd_data, dma_busy, ppu_wr, ppu_rd, prg_rd, ppu_reg_addr, ppu_wr_data, prg_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd=%h busy=%b wr=%b rd=%b prg_rd=%b ra=%h wd=%h pa=%h, all must be 0",
                     cpu_rd_data, dma_busy, ppu_wr, ppu_rd, prg_rd, ppu_reg_addr, ppu_wr_data, prg_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
    endtask

    task automatic test_ram_mirror;
        logic [15:0] a, m;
        logic [7:0]  d;
        cpu_write(16'h0005, 8'hA5);
        cpu_read(16'h1805);
        n_checks++;
        if (cpu_rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL ram_mirror_1805: got %h want a5", cpu_rd_data);
        end
        tick;
        n_checks++;
        if (cpu_rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL rd_data_hold: got %h want a5", cpu_rd_data);
        end
        cpu_read(16'h4000);
        n_checks++;
        if (cpu_rd_data !== 8'h00) begin
            n_fail++; $display("FAIL read_4000: got %h want 00", cpu_rd_data);
        end
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, 16'h1FFF));
            d = 8'($urandom);
            cpu_write(a, d);
            m = {3'b000, 2'($urandom_range(0, 3)), a[10:0]};
            cpu_read(m);
            n_checks++;
            if (cpu_rd_data !== exp_read(m)) begin
                n_fail++; $display("FAIL ram_rand a=%h: got %h want %h", m, cpu_rd_data, exp_read(m));
            end
            a = 16'($urandom_range(16'h4000, 16'h7FFF));
            cpu_read(a);
            n_checks++;
            if (cpu_rd_data !== 8'h00) begin
                n_fail++; $display("FAIL unmapped_read a=%h: got %h want 00", a, cpu_rd_data);
            end
        end
    endtask

    task automatic test_ppu;
        logic [15:0] a;
        cpu_addr = 16'h3FFA; cpu_wr_data = 8'h3C; cpu_write_en = 1'b1;
        #1;
        n_checks++;
        if ({ppu_wr, ppu_rd, ppu_reg_addr, ppu_wr_data} !== {1'b1, 1'b0, 3'd2, 8'h3C}) begin
            n_fail++; $display("FAIL ppu_write: wr=%b rd=%b ra=%h wd=%h want 1 0 2 3c",
                               ppu_wr, ppu_rd, ppu_reg_addr, ppu_wr_data);
        end
        tick;
        cpu_write_en = 1'b0;
        #1;
        n_checks++;
        if ({ppu_wr, ppu_reg_addr, ppu_wr_data} !== '0) begin
            n_fail++; $display("FAIL ppu_idle: wr=%b ra=%h wd=%h want 0", ppu_wr, ppu_reg_addr, ppu_wr_data);
        end
        for (int i = 0; i < 10; i++) begin
            a = (i == 0) ? 16'h2002 : 16'($urandom_range(16'h2000, 16'h3FFF));
            ppu_rd_data = (i == 0) ? 8'h80 : 8'($urandom);
            cpu_addr = a; cpu_read_en = 1'b1;
            #1;
            n_checks++;
            if ({ppu_rd, ppu_wr, prg_rd, ppu_reg_addr} !== {1'b1, 1'b0, 1'b0, a[2:0]}) begin
                n_fail++; $display("FAIL ppu_read_strobe a=%h: rd=%b wr=%b ra=%h", a, ppu_rd, ppu_wr, ppu_reg_addr);
            end
            tick;
            cpu_read_en = 1'b0;
            n_checks++;
            if (cpu_rd_data !== ppu_rd_data) begin
                n_fail++; $display("FAIL ppu_read_data a=%h: got %h want %h", a, cpu_rd_data, ppu_rd_data);
            end
        end
    endtask

    task automatic test_prg;
        logic [15:0] a;
        for (int i = 0; i < 10; i++) begin
            a = (i == 0) ? 16'hC123 : 16'($urandom_range(16'h8000, 16'hFFFF));
            cpu_addr = a; cpu_read_en = 1'b1;
            #1;
            n_checks++;
            if ({prg_rd, ppu_rd, prg_addr} !== {1'b1, 1'b0, a[14:0]}) begin
                n_fail++; $display("FAIL prg_strobe a=%h: prg_rd=%b addr=%h", a, prg_rd, prg_addr);
            end
            tick;
            cpu_read_en = 1'b0;
            n_checks++;
            if (cpu_rd_data !== rom_byte(a[14:0])) begin
                n_fail++; $display("FAIL prg_data a=%h: got %h want %h", a, cpu_rd_data, rom_byte(a[14:0]));
            end
        end
        cpu_write(16'h0000, 8'h5E);
        cpu_addr = 16'h8000; cpu_wr_data = 8'hE7; cpu_write_en = 1'b1;
        #1;
        n_checks++;
        if ({prg_rd, ppu_wr, ppu_rd} !== 3'b000) begin
            n_fail++; $display("FAIL prg_write_strobes: prg_rd=%b ppu_wr=%b ppu_rd=%b want 000", prg_rd, ppu_wr, ppu_rd);
        end
        tick;
        cpu_write_en = 1'b0;
        cpu_read(16'h0000);
        n_checks++;
        if (cpu_rd_data !== 8'h5E) begin
            n_fail++; $display("FAIL prg_write_dropped: ram[0]=%h want 5e", cpu_rd_data);
        end
    endtask

    task automatic test_simul_rw;
        logic [7:0] h, d;
        cpu_write(16'h0003, 8'h21);
        cpu_read(16'h0003);
        h = 8'h21;
        d = 8'($urandom) | 8'h40;
        cpu_addr = 16'h0010; cpu_wr_data = d; cpu_write_en = 1'b1; cpu_read_en = 1'b1;
        tick;
        cpu_write_en = 1'b0; cpu_read_en = 1'b0;
        ram_m[11'h010] = d;
        n_checks++;
        if (cpu_rd_data !== h) begin
            n_fail++; $display("FAIL simul_read_ignored: got %h want %h", cpu_rd_data, h);
        end
        cpu_read(16'h0010);
        n_checks++;
        if (cpu_rd_data !== d) begin
            n_fail++; $display("FAIL simul_write_done: got %h want %h", cpu_rd_data, d);
        end
    endtask

    task automatic fill_page(input logic [7:0] page, input bit random_data);
        for (int i = 0; i < 256; i++)
            cpu_write({page, 8'(i)}, random_data ? 8'($urandom) : 8'(i));
    endtask

    // Runs one full transfer. stop_after > 0 aborts with reset after that many ppu_wr.
    task automatic test_dma(input logic [7:0] page, input logic want_par, input int stop_after);
        logic [7:0] exp_b [256];
        logic [7:0] h;
        int busy_cnt, wr_cnt, first, k, done_k;
        bit done;
        cpu_read(16'h0003);
        h = ram_m[11'h003];
        for (int i = 0; i < 256; i++) exp_b[i] = exp_read({page, 8'(i)});
        for (int w = 0; w < 4 && tb_par !== want_par; w++) tick;
        first = want_par ? 4 : 3;
        cpu_addr = 16'h4014; cpu_wr_data = page; cpu_write_en = 1'b1;
        tick;
        cpu_write_en = 1'b0;
        busy_cnt = 0; wr_cnt = 0; done = 0; done_k = 0;
        for (k = 1; k < 600; k++) begin
            if (!done) begin
                if (dma_busy) busy_cnt++;
                else begin done = 1; done_k = k; end
            end
            if (ppu_wr) begin
                n_checks++;
                if (ppu_reg_addr !== 3'd4 || wr_cnt > 255 || ppu_wr_data !== exp_b[wr_cnt[7:0]] ||
                    k != first + 2 * wr_cnt) begin
                    n_fail++;
                    $display("FAIL dma_write n=%0d: cyc=%0d ra=%h data=%h want cyc=%0d ra=4 data=%h",
                             wr_cnt, k, ppu_reg_addr, ppu_wr_data, first + 2 * wr_cnt, exp_b[wr_cnt[7:0]]);
                end
                wr_cnt++;
            end
            if (dma_busy && (k % 16 == 5)) begin
                n_checks++;
                if (cpu_rd_data !== h) begin
                    n_fail++; $display("FAIL dma_rd_data_stable cyc=%0d: got %h want %h", k, cpu_rd_data, h);
                end
            end
            if (stop_after > 0 && wr_cnt == stop_after) break;
            if (done && k >= done_k + 3) break;
            if (dma_busy) begin
                // Stalled CPU noise: must all be ignored.
                cpu_read_en  = 1'($urandom);
                cpu_write_en = 1'($urandom);
                cpu_wr_data  = 8'($urandom);
                case ($urandom_range(0, 2))
                    0: cpu_addr = 16'h4014;
                    1: cpu_addr = {8'h02, 8'($urandom)};
                    default: cpu_addr = 16'($urandom);
                endcase
            end else begin
                cpu_read_en = 1'b0; cpu_write_en = 1'b0;
            end
            tick;
        end
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        if (stop_after > 0) begin
            tick;
            #2;
            rst = 1'b0;
            #1;
            n_checks++;
            if ({cpu_rd_data, dma_busy, ppu_wr, ppu_rd, prg_rd, ppu_reg_addr, ppu_wr_data, prg_addr} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_dma: rd=%h busy=%b wr=%b rd=%b prg_rd=%b ra=%h wd=%h pa=%h, all must be 0",
                         cpu_rd_data, dma_busy, ppu_wr, ppu_rd, prg_rd, ppu_reg_addr, ppu_wr_data, prg_addr);
            end
            n_checks++;
            if (wr_cnt != stop_after) begin
                n_fail++; $display("FAIL reset_mid_dma_count: saw %0d writes want %0d", wr_cnt, stop_after);
            end
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            tick;
        end else begin
            n_checks++;
            if (busy_cnt != 513 + int'(want_par)) begin
                n_fail++; $display("FAIL dma_busy_len page=%h: got %0d want %0d", page, busy_cnt, 513 + int'(want_par));
            end
            n_checks++;
            if (wr_cnt != 256) begin
                n_fail++; $display("FAIL dma_write_count page=%h: got %0d want 256", page, wr_cnt);
            end
            n_checks++;
            if (dma_busy !== 1'b0 || cpu_rd_data !== h) begin
                n_fail++; $display("FAIL dma_after: busy=%b rd=%h want 0 %h", dma_busy, cpu_rd_data, h);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ram_mirror;
        test_ppu;
        test_prg;
        test_simul_rw;
        fill_page(8'h02, 1'b0);
        ppu_rd_data = 8'h5A;
        test_dma(8'h02, 1'b0, 0);
        test_dma(8'h02, 1'b1, 0);
        test_dma(8'h81, 1'b0, 0);
        fill_page(8'h07, 1'b1);
        test_dma(8'h07, 1'b1, 100);
        fill_page(8'h07, 1'b1);
        test_dma(8'h07, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
